// File: rtl/magia_pkg.sv
// Shared L2 bank definitions: widths and the bank request/response payloads.
package magia_pkg;

    localparam int unsigned L2AddrWidth = 32;
    localparam int unsigned L2DataWidth = 32;
    localparam int unsigned L2BeWidth   = L2DataWidth / 8;

    typedef struct packed {
        logic                   we;
        logic [L2AddrWidth-1:0] addr;
        logic [L2BeWidth-1:0]   be;
        logic [L2DataWidth-1:0] wdata;
    } l2_mem_req_t;

    typedef struct packed {
        logic [L2DataWidth-1:0] rdata;
    } l2_mem_rsp_t;

    // Index width that stays legal for a single requester.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/magia_l2_bank_sched_if.sv
// Requester-side and bank-side signals of one L2 bank scheduler.
interface magia_l2_bank_sched_if #(
    parameter int unsigned NumIn     = 4,
    parameter int unsigned AddrWidth = magia_pkg::L2AddrWidth,
    parameter int unsigned DataWidth = magia_pkg::L2DataWidth
);
    localparam int unsigned BeWidth = DataWidth / 8;

    logic [NumIn-1:0]                in_req_i;
    logic [NumIn-1:0]                in_gnt_o;
    logic [NumIn-1:0]                in_we_i;
    logic [NumIn-1:0][AddrWidth-1:0] in_addr_i;
    logic [NumIn-1:0][BeWidth-1:0]   in_be_i;
    logic [NumIn-1:0][DataWidth-1:0] in_wdata_i;
    logic [NumIn-1:0]                in_rvalid_o;
    logic [NumIn-1:0][DataWidth-1:0] in_rdata_o;
    logic                            mem_req_o;
    logic                            mem_we_o;
    logic [AddrWidth-1:0]            mem_addr_o;
    logic [BeWidth-1:0]              mem_be_o;
    logic [DataWidth-1:0]            mem_wdata_o;
    logic [DataWidth-1:0]            mem_rdata_i;

    modport slave (
        input  in_req_i, in_we_i, in_addr_i, in_be_i, in_wdata_i, mem_rdata_i,
        output in_gnt_o, in_rvalid_o, in_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );

    modport master (
        output in_req_i, in_we_i, in_addr_i, in_be_i, in_wdata_i, mem_rdata_i,
        input  in_gnt_o, in_rvalid_o, in_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );

endinterface

// File: rtl/magia_l2_rr_arb.sv
// Round-robin winner select with a starvation boost; owns rr_ptr and the wait counters.
module magia_l2_rr_arb import magia_pkg::*; #(
    parameter  int unsigned NumIn   = 4,
    parameter  int unsigned MaxWait = 8,
    localparam int unsigned IdxW    = idx_w(NumIn)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NumIn-1:0] req_i,
    output logic [NumIn-1:0] gnt_o,
    output logic [IdxW-1:0]  idx_o,
    output logic             valid_o
);

    localparam int unsigned CntW = $clog2(MaxWait + 1);

    logic [IdxW-1:0]            rr_ptr;
    logic [NumIn-1:0][CntW-1:0] wait_cnt;
    logic [NumIn-1:0]           starved;

    always_comb begin
        for (int i = 0; i < NumIn; i++)
            starved[i] = req_i[i] && (wait_cnt[i] == CntW'(MaxWait));
    end

    // Descending scans so the last hit is the lowest index / nearest to rr_ptr.
    always_comb begin
        int j;
        j       = 0;
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = NumIn - 1; k >= 0; k--) begin
            if (starved[k]) begin
                valid_o = 1'b1;
                idx_o   = IdxW'(k);
            end
        end
        if (!valid_o) begin
            for (int k = NumIn - 1; k >= 0; k--) begin
                j = (int'(rr_ptr) + k) % int'(NumIn);
                if (req_i[j]) begin
                    valid_o = 1'b1;
                    idx_o   = IdxW'(j);
                end
            end
        end
        gnt_o = '0;
        if (valid_o) gnt_o[idx_o] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr   <= '0;
            wait_cnt <= '0;
        end else begin
            if (valid_o)
                rr_ptr <= (idx_o == IdxW'(NumIn - 1)) ? '0 : idx_o + IdxW'(1);
            for (int i = 0; i < NumIn; i++) begin
                if (req_i[i] && !gnt_o[i]) begin
                    if (wait_cnt[i] != CntW'(MaxWait)) wait_cnt[i] <= wait_cnt[i] + CntW'(1);
                end else begin
                    wait_cnt[i] <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/magia_l2_bank_sched.sv
// L2 bank scheduler: arbitrates NumIn requesters onto one SRAM port and routes
// fixed-latency responses back to the issuing requester.
module magia_l2_bank_sched import magia_pkg::*; #(
    parameter int unsigned NumIn      = 4,
    parameter int unsigned AddrWidth  = L2AddrWidth,
    parameter int unsigned DataWidth  = L2DataWidth,
    parameter int unsigned MemLatency = 1,
    parameter int unsigned MaxWait    = 8
) (
    input logic                  clk_i,
    input logic                  rst_i,
    magia_l2_bank_sched_if.slave bus
);

    localparam int unsigned IdxW = idx_w(NumIn);

    logic [NumIn-1:0] arb_gnt;
    logic [IdxW-1:0]  win_idx;
    logic             win_vld;
    logic             grant;
    l2_mem_req_t      win_req;
    l2_mem_rsp_t      rsp;

    logic [MemLatency-1:0]           vld_pipe;
    logic [MemLatency-1:0][IdxW-1:0] idx_pipe;

    magia_l2_rr_arb #(
        .NumIn   (NumIn),
        .MaxWait (MaxWait)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (bus.in_req_i),
        .gnt_o   (arb_gnt),
        .idx_o   (win_idx),
        .valid_o (win_vld)
    );

    // Everything requester- and bank-facing is forced quiet while in reset.
    assign grant        = win_vld & ~rst_i;
    assign bus.in_gnt_o = rst_i ? '0 : arb_gnt;

    always_comb begin
        win_req = '0;
        if (grant) begin
            win_req.we    = bus.in_we_i[win_idx];
            win_req.addr  = bus.in_addr_i[win_idx];
            win_req.be    = bus.in_be_i[win_idx];
            win_req.wdata = bus.in_wdata_i[win_idx];
        end
    end

    assign bus.mem_req_o   = grant;
    assign bus.mem_we_o    = win_req.we;
    assign bus.mem_addr_o  = win_req.addr;
    assign bus.mem_be_o    = win_req.be;
    assign bus.mem_wdata_o = win_req.wdata;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe <= '0;
            idx_pipe <= '0;
        end else begin
            vld_pipe[0] <= win_vld;
            idx_pipe[0] <= win_idx;
            for (int s = 1; s < MemLatency; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                idx_pipe[s] <= idx_pipe[s-1];
            end
        end
    end

    always_comb begin
        bus.in_rvalid_o = '0;
        if (vld_pipe[MemLatency-1]) bus.in_rvalid_o[idx_pipe[MemLatency-1]] = 1'b1;
    end

    assign rsp.rdata = bus.mem_rdata_i;

    always_comb begin
        for (int i = 0; i < NumIn; i++)
            bus.in_rdata_o[i] = rst_i ? '0 : rsp.rdata;
    end

endmodule

// File: tb/tb_magia_l2_bank_sched.sv
// Bench for magia_l2_bank_sched: requester/SRAM models plus a rule-level scoreboard.
module tb_magia_l2_bank_sched;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int L  = 2;
    localparam int MW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    magia_l2_bank_sched_if #(.NumIn(N), .AddrWidth(AW), .DataWidth(DW)) bif();

    magia_l2_bank_sched #(
        .NumIn(N), .AddrWidth(AW), .DataWidth(DW), .MemLatency(L), .MaxWait(MW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bif.slave)
    );

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;

    bit            rq_v [N];
    bit            rq_we[N];
    logic [AW-1:0] rq_addr[N];
    logic [BW-1:0] rq_be[N];
    logic [DW-1:0] rq_wd[N];
    int            mode;     // 0 hand-driven, 1 always re-request, 2 random
    int            req_pct;

    int            m_rr;
    int            m_w[N];
    int            m_win;
    logic [DW-1:0] shadow[256];
    typedef struct { int due; int idx; bit we; logic [DW-1:0] data; } rsp_t;
    rsp_t          rsp_q[$];

    logic [N-1:0]  seen_gnt, seen_rv;
    logic [DW-1:0] seen_rd[N];

    function automatic logic [DW-1:0] init_word(int a);
        logic [15:0] ba;
        ba = 16'(a * 4);
        return {ba, ~ba};
    endfunction

    function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] wd, logic [BW-1:0] be);
        for (int b = 0; b < BW; b++) if (be[b]) old[8*b +: 8] = wd[8*b +: 8];
        return old;
    endfunction

    // Bench SRAM: reads land on mem_rdata_i L cycles after the request.
    logic [DW-1:0] sram[256];
    logic [DW-1:0] rd_pipe[L];
    always @(posedge clk) begin
        for (int s = L - 1; s > 0; s--) rd_pipe[s] <= rd_pipe[s-1];
        rd_pipe[0] <= 32'hDEAD_BEEF;
        if (bif.mem_req_o) begin
            if (bif.mem_we_o)
                sram[bif.mem_addr_o[9:2]] = merge(sram[bif.mem_addr_o[9:2]], bif.mem_wdata_o, bif.mem_be_o);
            else
                rd_pipe[0] <= sram[bif.mem_addr_o[9:2]];
        end
    end
    assign bif.mem_rdata_i = rd_pipe[L-1];

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bif.in_req_i[i]   = rq_v[i];
            bif.in_we_i[i]    = rq_we[i];
            bif.in_addr_i[i]  = rq_addr[i];
            bif.in_be_i[i]    = rq_be[i];
            bif.in_wdata_i[i] = rq_wd[i];
        end
    endtask

    task automatic set_req(int i, bit we, logic [AW-1:0] a, logic [BW-1:0] be, logic [DW-1:0] wd);
        rq_v[i] = 1'b1; rq_we[i] = we; rq_addr[i] = a; rq_be[i] = be; rq_wd[i] = wd;
        drive();
    endtask

    task automatic rand_req(int i);
        rq_v[i]    = 1'b1;
        rq_we[i]   = 1'($urandom_range(0, 1));
        rq_addr[i] = 32'h100 + 32'($urandom_range(0, 15)) * 4;
        rq_be[i]   = 4'($urandom_range(1, 15));
        rq_wd[i]   = $urandom;
    endtask

    // Starved requesters first (lowest index), otherwise first requester at or after rr.
    function automatic int model_winner();
        for (int i = 0; i < N; i++) if (rq_v[i] && m_w[i] == MW) return i;
        for (int k = 0; k < N; k++) if (rq_v[(m_rr + k) % N]) return (m_rr + k) % N;
        return -1;
    endfunction

    task automatic check_cycle();
        logic [N-1:0] eg, erv;
        int w;
        w = model_winner();
        m_win = w;
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        chk("gnt", bif.in_gnt_o, eg);
        chk("mem_req", bif.mem_req_o, w >= 0);
        if (w >= 0)
            chk("mem_payload", {bif.mem_we_o, bif.mem_addr_o, bif.mem_be_o, bif.mem_wdata_o},
                {rq_we[w], rq_addr[w], rq_be[w], rq_wd[w]});
        else
            chk("mem_idle", {bif.mem_we_o, bif.mem_addr_o, bif.mem_be_o, bif.mem_wdata_o}, '0);
        erv = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) erv[rsp_q[0].idx] = 1'b1;
        chk("rvalid", bif.in_rvalid_o, erv);
        if (erv != '0) begin
            if (!rsp_q[0].we) chk("rdata", bif.in_rdata_o[rsp_q[0].idx], rsp_q[0].data);
            void'(rsp_q.pop_front());
        end
        seen_gnt = bif.in_gnt_o;
        seen_rv  = bif.in_rvalid_o;
        for (int i = 0; i < N; i++) seen_rd[i] = bif.in_rdata_o[i];
    endtask

    task automatic model_update();
        rsp_t r;
        int   a;
        for (int i = 0; i < N; i++)
            m_w[i] = (rq_v[i] && i != m_win) ? ((m_w[i] < MW) ? m_w[i] + 1 : MW) : 0;
        if (m_win >= 0) begin
            a      = int'(rq_addr[m_win][9:2]);
            r.due  = cyc + L;
            r.idx  = m_win;
            r.we   = rq_we[m_win];
            r.data = shadow[a];
            if (rq_we[m_win]) shadow[a] = merge(shadow[a], rq_wd[m_win], rq_be[m_win]);
            rsp_q.push_back(r);
            m_rr = (m_win + 1) % N;
            rq_v[m_win] = 1'b0;
        end
    endtask

    task automatic new_reqs();
        for (int i = 0; i < N; i++)
            if (!rq_v[i] && (mode == 1 || (mode == 2 && int'($urandom_range(0, 99)) < req_pct)))
                rand_req(i);
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        model_update();
        cyc++;
        new_reqs();
        drive();
    endtask

    task automatic chk_quiet(string tag);
        chk({tag, "_gnt"}, bif.in_gnt_o, '0);
        chk({tag, "_mem"}, {bif.mem_req_o, bif.mem_we_o, bif.mem_addr_o, bif.mem_be_o, bif.mem_wdata_o}, '0);
        chk({tag, "_rvalid"}, bif.in_rvalid_o, '0);
        chk({tag, "_rdata"}, bif.in_rdata_o, '0);
    endtask

    // Called just after a rising edge; pending requests stay raised across reset.
    task automatic do_reset();
        rst = 1'b1;
        rsp_q.delete();
        m_rr = 0;
        for (int i = 0; i < N; i++) m_w[i] = 0;
        @(negedge clk);
        chk_quiet("rst");
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] exp_g[6];
        for (int a = 0; a < 256; a++) begin
            sram[a]   = init_word(a);
            shadow[a] = init_word(a);
        end
        for (int s = 0; s < L; s++) rd_pipe[s] = '0;
        for (int i = 0; i < N; i++) begin
            rq_v[i] = 1'b0; rq_we[i] = 1'b0; rq_addr[i] = '0; rq_be[i] = '0; rq_wd[i] = '0;
            m_w[i] = 0;
        end
        m_rr = 0; mode = 0; req_pct = 0;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_quiet("init_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single read at 0x100: same-cycle grant, data two cycles later.
        set_req(0, 1'b0, 32'h100, 4'hF, '0);
        step(); chk("t1_gnt", seen_gnt, 4'b0001);
        step(); step();
        chk("t1_rvalid", seen_rv, 4'b0001);
        chk("t1_rdata", seen_rd[0], 32'h0100_FEFF);

        // Partial write then read-back of the same word.
        set_req(1, 1'b1, 32'h100, 4'b0011, 32'hAABB_CCDD);
        step(); chk("t2_wr_gnt", seen_gnt, 4'b0010);
        set_req(1, 1'b0, 32'h100, 4'h0, '0);
        step(); chk("t2_rd_gnt", seen_gnt, 4'b0010);
        step(); chk("t2_wr_rvalid", seen_rv, 4'b0010);
        step(); chk("t2_rd_rvalid", seen_rv, 4'b0010);
        chk("t2_rdata", seen_rd[1], 32'h0100_CCDD);

        // Idle gap leaves rr at 2, so of {0,3} requester 3 goes first.
        repeat (3) step();
        set_req(0, 1'b0, 32'h104, 4'hF, '0);
        set_req(3, 1'b0, 32'h108, 4'hF, '0);
        step(); chk("idle_rr_gnt", seen_gnt, 4'b1000);
        step(); chk("idle_rr_gnt2", seen_gnt, 4'b0001);

        // Requester 0 waits two cycles and then beats rr (pointing at 3).
        set_req(1, 1'b0, 32'h10C, 4'hF, '0);
        set_req(0, 1'b1, 32'h110, 4'hF, 32'h1234_5678);
        step(); chk("starve_g1", seen_gnt, 4'b0010);
        set_req(2, 1'b0, 32'h110, 4'hF, '0);
        step(); chk("starve_g2", seen_gnt, 4'b0100);
        set_req(3, 1'b0, 32'h114, 4'hF, '0);
        step(); chk("starve_boost", seen_gnt, 4'b0001);
        step(); chk("starve_after", seen_gnt, 4'b1000);
        repeat (3) step();

        // Two responses in flight when reset hits; they must never come back.
        set_req(1, 1'b0, 32'h118, 4'hF, '0);
        set_req(2, 1'b0, 32'h11C, 4'hF, '0);
        step(); step();
        mode = 1;
        new_reqs();
        drive();
        do_reset();

        // Continuous load with MaxWait=2: requester 3 keeps losing to lower boosted indices.
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100};
        for (int k = 0; k < 6; k++) begin
            step();
            chk("cont_gnt", seen_gnt, exp_g[k]);
            if (k < 2) chk("post_rst_rvalid", seen_rv, '0);
            else       chk("cont_rvalid", seen_rv, exp_g[k-2]);
        end
        for (int i = 0; i < N; i++) rq_v[i] = 1'b0;
        mode = 0;
        drive();
        repeat (4) step();

        mode = 2;
        for (int blk = 0; blk < 4; blk++) begin
            req_pct = 15 + blk * 28;
            repeat (600) step();
            do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/magia_l2_bank_sched.md
Name: magia_l2_bank_sched

Overview:
- Request scheduler in front of one single-ported L2 SRAM bank in the mesh L2 memory subsystem.
- Shares the bank between NumIn requesters, e.g. per-port AXI-to-mem converters behind the L2 network interfaces.
- Round-robin arbitration with a starvation-boost override.
- Fixed-latency response routing back to the requester that issued each request.

Parameters:
- NumIn, 4, number of requesters (≥2).
- AddrWidth, 32, address width.
- DataWidth, 32, data width; BeWidth = DataWidth/8.
- MemLatency, 1, cycles from mem_req_o to valid mem_rdata_i (≥1).
- MaxWait, 8, wait cycles after which a requester is boosted (≥1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high.
- in_req_i  in  NumIn  per-requester request.
- in_gnt_o  out  NumIn  per-requester grant (one-hot or zero).
- in_we_i  in  NumIn  write enable.
- in_addr_i  in  NumIn×AddrWidth  address.
- in_be_i  in  NumIn×BeWidth  byte enables.
- in_wdata_i  in  NumIn×DataWidth  write data.
- in_rvalid_o  out  NumIn  response valid (reads and writes).
- in_rdata_o  out  NumIn×DataWidth  read data (all lanes driven from mem_rdata_i).
- mem_req_o  out  1  bank request.
- mem_we_o  out  1  bank write enable.
- mem_addr_o  out  AddrWidth  bank address.
- mem_be_o  out  BeWidth  bank byte enables.
- mem_wdata_o  out  DataWidth  bank write data.
- mem_rdata_i  in  DataWidth  bank read data.

Behaviour:
- Handshake:
  - A requester holds req and payload stable until gnt.
  - gnt is combinational in the same cycle.
  - One grant per cycle; the bank accepts every cycle, so mem_req_o = |in_req_i.
- Mux: mem_* carry the winner's payload. When there is no winner, mem_req_o=0 and the other mem_* outputs are 0.
- Round-robin:
  - rr_ptr (clog2(NumIn) bits, reset 0).
  - The winner is the first requesting index scanning upward from rr_ptr, wrapping at NumIn.
  - After a grant, rr_ptr = (winner+1) mod NumIn. With no grant, rr_ptr holds.
- Starvation:
  - wait_cnt[i] (reset 0) increments, saturating at MaxWait, each cycle req_i=1 and gnt_i=0.
  - It clears on gnt_i or when req_i=0.
  - If any wait_cnt equals MaxWait, the lowest such index wins and overrides round-robin. rr_ptr is still updated to winner+1.
- Response pipeline:
  - Shift register of depth MemLatency carrying {valid, winner index}.
  - Stage 0 is loaded on each grant, with valid=0 when nothing is granted.
  - in_rvalid_o[idx] is pulsed for 1 cycle exactly MemLatency cycles after the grant cycle, for reads and writes alike.
  - in_rdata_o is meaningful only for reads.
  - Back-to-back grants give back-to-back rvalids in grant order.
- Simultaneous events: a grant to requester i and an rvalid to requester i in the same cycle are both allowed.
- Reset:
  - All outputs 0; rr_ptr, wait_cnt and pipeline cleared.
  - Asserting rst_i mid-operation discards in-flight responses: no rvalid is issued for them after reset.
- No combinational path from mem_rdata_i to any grant.

Decomposition:
- Shared package (magia_pkg):
  - L2 bank address/data width constants.
  - Typedef l2_mem_req_t {we, addr, be, wdata}.
  - Typedef l2_mem_rsp_t {rdata}.
- One sub-module: magia_l2_rr_arb, the round-robin plus starvation-boost winner selection holding rr_ptr and wait_cnt. The top level holds the mux and response pipeline.

Test Plan:
- Single requester: req0 read addr 0x100, MemLatency=2 → gnt0 in the same cycle; rvalid0 two cycles later with the bank data; rr_ptr=1.
- All 4 requesting continuously → grants 0,1,2,3,0,… one per cycle; rvalids follow in the same order, each lagging its grant by MemLatency.
- Write then read of the same address (be=4'b0011, wdata 0xAABBCCDD) → rvalid for the write; the read returns 0x????CCDD, with upper bytes holding the prior content.
- Starvation, MaxWait=2: gnt is forced to requester 2 with others ignored until wait_cnt[2]=2 → req2 wins on the next cycle despite rr_ptr, and rr_ptr becomes 3.
- rst_i pulsed while 2 responses are in flight → no rvalid after reset; all outputs 0 during reset; first grant after release starts from index 0.
- Idle cycles between requests → mem_req_o=0, no spurious rvalid, rr_ptr unchanged.
